// File: rtl/fifo_if.sv
// Push/pop handshake bundle for the synchronous FIFO.
// The slave modport is the FIFO side and the master modport is the producer/consumer side.
interface fifo_if #(
    parameter int DATA_W = 16
);
    logic              push_i;
    logic [DATA_W-1:0] push_data_i;
    logic              pop_i;
    logic [DATA_W-1:0] pop_data_o;
    logic              full_o;
    logic              empty_o;

    modport slave (
        input  push_i,
        input  push_data_i,
        input  pop_i,
        output pop_data_o,
        output full_o,
        output empty_o
    );

    modport master (
        output push_i,
        output push_data_i,
        output pop_i,
        input  pop_data_o,
        input  full_o,
        input  empty_o
    );
endinterface

// File: rtl/fifo.sv
// Synchronous first-word-fall-through FIFO. The pointers carry one extra wrap bit
// so that the full and empty states can be told apart.
module fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic   clk,
    input  logic   reset,
    fifo_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW-1:0]     rd_ptr_d;
    logic              full_s;
    logic              empty_s;
    logic              push_acc_s;
    logic              pop_acc_s;

    // Status flags and handshake acceptance, derived from the registered pointers.
    always_comb begin
        empty_s    = (wr_ptr_q == rd_ptr_q);
        full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_acc_s  = bus.pop_i && !empty_s;
        // When full, a push is accepted only if a pop frees the head slot in the same cycle.
        push_acc_s = bus.push_i && (!full_s || pop_acc_s);
    end

    // Next-state pointers and storage write.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push_acc_s) begin
            wr_ptr_d                  = wr_ptr_q + PTR_ONE;
            mem_d[wr_ptr_q[AW-1:0]]   = bus.push_data_i;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_acc_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Outputs: head word falls through combinationally and reads as zero when empty.
    always_comb begin
        bus.full_o  = full_s;
        bus.empty_o = empty_s;
        if (empty_s) begin
            bus.pop_data_o = {DATA_W{1'b0}};
        end else begin
            bus.pop_data_o = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; its contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for the FIFO with DATA_W=16 and DEPTH=8.
module tb_fifo;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    fifo_if #(.DATA_W(16)) bus ();

    fifo #(.DATA_W(16), .DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic push, input logic [15:0] data, input logic pop);
        bus.push_i      = push;
        bus.push_data_i = data;
        bus.pop_i       = pop;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        // Reset with push and pop requested; both must be ignored.
        reset = 1'b1;
        drive(1'b1, 16'hDEAD, 1'b1);
        tick();
        reset = 1'b0;
        drive(1'b0, 16'h0000, 1'b0);
        tick();
        tick();
        check("rst_empty", {15'd0, bus.empty_o}, 16'd1);
        check("rst_full",  {15'd0, bus.full_o},  16'd0);
        check("rst_data",  bus.pop_data_o, 16'h0000);

        // Fill D0..D7.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'hA000 + 16'(i), 1'b0);
            tick();
            check("fill_empty", {15'd0, bus.empty_o}, 16'd0);
            check("fill_head",  bus.pop_data_o, 16'hA000);
            check("fill_full",  {15'd0, bus.full_o}, (i == 7) ? 16'd1 : 16'd0);
        end
        // Push on full is dropped.
        drive(1'b1, 16'hBEEF, 1'b0);
        tick();
        check("ovf_full", {15'd0, bus.full_o}, 16'd1);
        check("ovf_head", bus.pop_data_o, 16'hA000);

        // Drain in order.
        for (int i = 0; i < 8; i++) begin
            check("drain_data", bus.pop_data_o, 16'hA000 + 16'(i));
            drive(1'b0, 16'h0000, 1'b1);
            tick();
            check("drain_full",  {15'd0, bus.full_o}, 16'd0);
            check("drain_empty", {15'd0, bus.empty_o}, (i == 7) ? 16'd1 : 16'd0);
        end
        // Pop on empty is dropped.
        tick();
        check("udf_empty", {15'd0, bus.empty_o}, 16'd1);
        check("udf_data",  bus.pop_data_o, 16'h0000);

        // Simultaneous push and pop while empty: push accepted.
        drive(1'b1, 16'h5A5A, 1'b1);
        tick();
        check("pp_empty_empty", {15'd0, bus.empty_o}, 16'd0);
        check("pp_empty_data",  bus.pop_data_o, 16'h5A5A);
        drive(1'b0, 16'h0000, 1'b1);
        tick();
        check("pp_empty_drain", {15'd0, bus.empty_o}, 16'd1);

        // One word in flight, then eight streaming push+pop cycles.
        drive(1'b1, 16'h0A0A, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("stream_data", bus.pop_data_o, (i == 0) ? 16'h0A0A : 16'hB000 + 16'(i - 1));
            drive(1'b1, 16'hB000 + 16'(i), 1'b1);
            tick();
            check("stream_empty", {15'd0, bus.empty_o}, 16'd0);
            check("stream_full",  {15'd0, bus.full_o},  16'd0);
        end
        drive(1'b0, 16'h0000, 1'b0);
        check("stream_tail", bus.pop_data_o, 16'hB007);
        drive(1'b0, 16'h0000, 1'b1);
        tick();
        check("stream_drain", {15'd0, bus.empty_o}, 16'd1);

        // Fill, then push+pop while full: both accepted, stays full.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'hC000 + 16'(i), 1'b0);
            tick();
        end
        check("pp_full_pre", {15'd0, bus.full_o}, 16'd1);
        drive(1'b1, 16'hCCCC, 1'b1);
        tick();
        check("pp_full_full", {15'd0, bus.full_o}, 16'd1);
        for (int i = 0; i < 8; i++) begin
            check("pp_full_order", bus.pop_data_o, (i == 7) ? 16'hCCCC : 16'hC001 + 16'(i));
            drive(1'b0, 16'h0000, 1'b1);
            tick();
        end
        check("pp_full_empty", {15'd0, bus.empty_o}, 16'd1);

        // Mid-operation reset discards contents.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'hE000 + 16'(i), 1'b0);
            tick();
        end
        check("mid_pre_head", bus.pop_data_o, 16'hE000);
        drive(1'b0, 16'h0000, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_empty", {15'd0, bus.empty_o}, 16'd1);
        check("mid_full",  {15'd0, bus.full_o},  16'd0);
        check("mid_data",  bus.pop_data_o, 16'h0000);
        drive(1'b1, 16'h1234, 1'b0);
        tick();
        check("post_rst_data", bus.pop_data_o, 16'h1234);
        drive(1'b0, 16'h0000, 1'b1);
        tick();
        check("post_rst_empty", {15'd0, bus.empty_o}, 16'd1);
        drive(1'b0, 16'h0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
